// File: rtl/flag_pkg.sv
// flag_pkg: shared opcode classification for the condition-flag path.
//   - OP_BR_PREFIX / OP_SHIFT_PREFIX : opcode[4:2] class prefixes
//   - BRZ/BRNZ/BRC/BRNC              : the four flag-reading branch opcodes
//   - is_wr(op)                       : opcode updates C/Z
//   - is_br(op)                       : opcode reads C/Z in ID
package flag_pkg;

  localparam int unsigned OPCODE_W = 5;

  localparam logic [2:0] OP_BR_PREFIX    = 3'b101;
  localparam logic [2:0] OP_SHIFT_PREFIX = 3'b110;

  localparam logic [OPCODE_W-1:0] BRZ  = 5'b10100;
  localparam logic [OPCODE_W-1:0] BRNZ = 5'b10101;
  localparam logic [OPCODE_W-1:0] BRC  = 5'b10110;
  localparam logic [OPCODE_W-1:0] BRNC = 5'b10111;

  // ALU ops (0xxxx) and shifts (110xx) write flags; memory, branch, jump
  // (10xxx) and 111xx leave them alone.
  function automatic logic is_wr(input logic [OPCODE_W-1:0] op);
    return (op[4] == 1'b0) || (op[4:2] == OP_SHIFT_PREFIX);
  endfunction

  function automatic logic is_br(input logic [OPCODE_W-1:0] op);
    return (op[4:2] == OP_BR_PREFIX);
  endfunction

endpackage

// File: rtl/flag_pipe_reg.sv
// flag_pipe_reg: MEM-stage holding register for a pending flag update.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   freeze_i           : hold all state this cycle
//   wr_i, c_i, z_i     : EX-stage write-enable and new flag values
//   wr_o, c_o, z_o     : registered MEM-stage copy
module flag_pipe_reg
  import flag_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic freeze_i,
  input  logic wr_i,
  input  logic c_i,
  input  logic z_i,
  output logic wr_o,
  output logic c_o,
  output logic z_o
);

  logic wr_q, c_q, z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= 1'b0;
      c_q  <= 1'b0;
      z_q  <= 1'b0;
    end else if (!freeze_i) begin
      wr_q <= wr_i;
      c_q  <= c_i;
      z_q  <= z_i;
    end
  end

  assign wr_o = wr_q;
  assign c_o  = c_q;
  assign z_o  = z_q;

endmodule

// File: rtl/flag_unit.sv
// flag_unit: produces Carry/Zero from the EX-stage ALU result, holds the
// architectural C/Z registers and presents a flag view to the ID branch
// checker, stalling ID when a branch would read a flag still in flight.
// Parameters:
//   DATA_W       : ALU result width used for the Zero test
//   COMMIT_STAGE : 1 = commit at end of EX, 2 = commit at end of MEM
//   FWD_EN       : 1 = bypass pending flags to ID, 0 = stall ID instead
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   ex_valid, ex_opCode, ex_result : EX instruction, opcode, ALU result
//   ex_cout, ex_flush              : ALU carry-out, kill EX instruction
//   freeze                         : global pipeline hold
//   id_opCode                      : opcode of the instruction in ID
//   Cout, Zout                     : flag view for branch logic
//   flag_stall                     : ID branch must stall
//   C_q, Z_q                       : architectural carry / zero registers
module flag_unit
  import flag_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int COMMIT_STAGE = 1,
  parameter int FWD_EN       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opCode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_cout,
  input  logic              ex_flush,
  input  logic              freeze,
  input  logic [4:0]        id_opCode,
  output logic              Cout,
  output logic              Zout,
  output logic              flag_stall,
  output logic              C_q,
  output logic              Z_q
);

  // EX-stage flag source
  logic ex_wr, new_c, new_z;

  assign ex_wr = ex_valid & ~ex_flush & is_wr(ex_opCode);
  assign new_z = (ex_result == '0);
  assign new_c = ex_cout;

  // Optional MEM stage; tied off to "nothing pending" when commit is in EX.
  logic mem_wr, mem_c, mem_z;

  generate
    if (COMMIT_STAGE == 2) begin : g_mem
      flag_pipe_reg u_mem (
        .clk      (clk),
        .rst      (rst),
        .freeze_i (freeze),
        .wr_i     (ex_wr),
        .c_i      (new_c),
        .z_i      (new_z),
        .wr_o     (mem_wr),
        .c_o      (mem_c),
        .z_o      (mem_z)
      );
    end else begin : g_no_mem
      assign mem_wr = 1'b0;
      assign mem_c  = 1'b0;
      assign mem_z  = 1'b0;
    end
  endgenerate

  // Architectural register next state. freeze blocks every update,
  // including a MEM commit, so nothing is lost while held.
  logic c_d, z_d;

  always_comb begin
    c_d = C_q;
    z_d = Z_q;
    if (!freeze) begin
      if (COMMIT_STAGE == 2) begin
        if (mem_wr) begin
          c_d = mem_c;
          z_d = mem_z;
        end
      end else if (ex_wr) begin
        c_d = new_c;
        z_d = new_z;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C_q <= 1'b0;
      Z_q <= 1'b0;
    end else begin
      C_q <= c_d;
      Z_q <= z_d;
    end
  end

  // Without bypass, a branch in ID must wait while any writer is in flight.
  logic stall_raw;
  assign stall_raw = is_br(id_opCode) & (ex_wr | mem_wr);

  // Flag view: youngest in-flight writer wins (EX over MEM over arch).
  always_comb begin
    Cout       = C_q;
    Zout       = Z_q;
    flag_stall = 1'b0;
    if (FWD_EN != 0) begin
      if (ex_wr) begin
        Cout = new_c;
        Zout = new_z;
      end else if (mem_wr) begin
        Cout = mem_c;
        Zout = mem_z;
      end
    end else begin
      flag_stall = stall_raw;
    end
  end

endmodule
